mem_stage: RTL and testbench

//   MEM stage of the 5-stage RV32I pipeline; the consumer of the EX/MEM register's
//   mem_addr/mem_rmask/mem_wmask/mem_wdata/funct3 fields.

---
 rtl/mem_stage_if.sv | 51 +++++
 rtl/mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle of the EX/MEM request fields, the data-memory port and the MEM/WB results
// that connect the MEM stage to the rest of the pipeline.
interface mem_stage_if #(
  parameter int unsigned STALL_CNT_W = 32
) ();

  // EX/MEM request
  logic                   req_valid;
  logic [31:0]            req_addr;
  logic [3:0]             req_rmask;
  logic [3:0]             req_wmask;
  logic [31:0]            req_wdata;
  logic [2:0]             req_funct3;
  logic [4:0]             req_rd_s;
  logic                   req_regf_we;
  logic [31:0]            req_alu_result;

  // Data memory
  logic [31:0]            dmem_addr;
  logic [3:0]             dmem_rmask;
  logic [3:0]             dmem_wmask;
  logic [31:0]            dmem_wdata;
  logic [31:0]            dmem_rdata;
  logic                   dmem_resp;

  // Pipeline control, MEM/WB and status
  logic                   stall;
  logic                   wb_valid;
  logic [4:0]             wb_rd_s;
  logic                   wb_regf_we;
  logic [31:0]            wb_rd_v;
  logic                   misalign;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Pipeline / memory side that drives requests and responses
  modport master (
    output req_valid, req_addr, req_rmask, req_wmask, req_wdata, req_funct3,
           req_rd_s, req_regf_we, req_alu_result, dmem_rdata, dmem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, stall, wb_valid,
           wb_rd_s, wb_regf_we, wb_rd_v, misalign, stall_cnt
  );

  // MEM stage itself
  modport slave (
    input  req_valid, req_addr, req_rmask, req_wmask, req_wdata, req_funct3,
           req_rd_s, req_regf_we, req_alu_result, dmem_rdata, dmem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, stall, wb_valid,
           wb_rd_s, wb_regf_we, wb_rd_v, misalign, stall_cnt
  );

endinterface

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: issues one data-memory request per load/store,
// stalls upstream until the response, extracts/extends load data and registers MEM/WB.
module mem_stage #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Request registers driving the memory port
  logic [31:0] r_dmem_addr,  w_dmem_addr_nxt;
  logic [3:0]  r_dmem_rmask, w_dmem_rmask_nxt;
  logic [3:0]  r_dmem_wmask, w_dmem_wmask_nxt;
  logic [31:0] r_dmem_wdata, w_dmem_wdata_nxt;

  // Instruction context captured at acceptance, used when the response returns
  logic [2:0]  r_funct3,     w_funct3_nxt;
  logic [1:0]  r_lane,       w_lane_nxt;
  logic [4:0]  r_rd_s,       w_rd_s_nxt;
  logic        r_regf_we,    w_regf_we_nxt;
  logic        r_is_load,    w_is_load_nxt;

  // MEM/WB outputs
  logic        r_wb_valid,   w_wb_valid_nxt;
  logic [4:0]  r_wb_rd_s,    w_wb_rd_s_nxt;
  logic        r_wb_regf_we, w_wb_regf_we_nxt;
  logic [31:0] r_wb_rd_v,    w_wb_rd_v_nxt;
  logic        r_misalign,   w_misalign_nxt;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_stall;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_mem_op = bus.req_valid & ((|bus.req_rmask) | (|bus.req_wmask));

  // Half accesses need an even address, word accesses a word-aligned one.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   w_misaligned = bus.req_addr[0];
      2'b10:   w_misaligned = |bus.req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // Select the addressed lane of the response word and extend it to the load width.
  always_comb begin
    w_byte      = bus.dmem_rdata[{r_lane, 3'b000} +: 8];
    w_half      = r_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    w_load_data = bus.dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = bus.dmem_rdata;
    endcase
  end

  // FSM state register; reset drops any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and next values of every datapath register.
  always_comb begin
    w_state_nxt      = r_state;
    w_stall          = 1'b0;
    w_dmem_addr_nxt  = r_dmem_addr;
    w_dmem_rmask_nxt = 4'b0000;
    w_dmem_wmask_nxt = 4'b0000;
    w_dmem_wdata_nxt = r_dmem_wdata;
    w_funct3_nxt     = r_funct3;
    w_lane_nxt       = r_lane;
    w_rd_s_nxt       = r_rd_s;
    w_regf_we_nxt    = r_regf_we;
    w_is_load_nxt    = r_is_load;
    w_wb_valid_nxt   = r_wb_valid;
    w_wb_rd_s_nxt    = r_wb_rd_s;
    w_wb_regf_we_nxt = r_wb_regf_we;
    w_wb_rd_v_nxt    = r_wb_rd_v;
    w_misalign_nxt   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (!w_mem_op) begin
          w_wb_valid_nxt   = bus.req_valid;
          w_wb_rd_s_nxt    = bus.req_rd_s;
          w_wb_regf_we_nxt = bus.req_regf_we & (bus.req_rd_s != 5'd0);
          w_wb_rd_v_nxt    = bus.req_alu_result;
        end else if (w_misaligned) begin
          // Suppressed access retires as a harmless no-write entry.
          w_wb_valid_nxt   = 1'b1;
          w_wb_rd_s_nxt    = bus.req_rd_s;
          w_wb_regf_we_nxt = 1'b0;
          w_wb_rd_v_nxt    = 32'h0;
          w_misalign_nxt   = 1'b1;
        end else begin
          w_stall          = 1'b1;
          w_dmem_addr_nxt  = {bus.req_addr[31:2], 2'b00};
          w_dmem_rmask_nxt = bus.req_rmask;
          w_dmem_wmask_nxt = bus.req_wmask;
          w_dmem_wdata_nxt = bus.req_wdata;
          w_funct3_nxt     = bus.req_funct3;
          w_lane_nxt       = bus.req_addr[1:0];
          w_rd_s_nxt       = bus.req_rd_s;
          w_regf_we_nxt    = bus.req_regf_we & (bus.req_rd_s != 5'd0);
          w_is_load_nxt    = |bus.req_rmask;
          w_wb_valid_nxt   = 1'b0;
          w_state_nxt      = StIssue;
        end
      end
      StIssue: begin
        w_stall        = 1'b1;
        w_wb_valid_nxt = 1'b0;
        w_state_nxt    = StWait;
      end
      StWait: begin
        w_stall = ~bus.dmem_resp;
        if (bus.dmem_resp) begin
          w_wb_valid_nxt   = 1'b1;
          w_wb_rd_s_nxt    = r_rd_s;
          w_wb_regf_we_nxt = r_is_load & r_regf_we;
          w_wb_rd_v_nxt    = r_is_load ? w_load_data : 32'h0;
          w_state_nxt      = StIdle;
        end else begin
          w_wb_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Datapath and MEM/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_addr  <= 32'h0;
      r_dmem_rmask <= 4'b0000;
      r_dmem_wmask <= 4'b0000;
      r_dmem_wdata <= 32'h0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_rd_s       <= 5'd0;
      r_regf_we    <= 1'b0;
      r_is_load    <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_s    <= 5'd0;
      r_wb_regf_we <= 1'b0;
      r_wb_rd_v    <= 32'h0;
      r_misalign   <= 1'b0;
    end else begin
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_rmask <= w_dmem_rmask_nxt;
      r_dmem_wmask <= w_dmem_wmask_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
      r_funct3     <= w_funct3_nxt;
      r_lane       <= w_lane_nxt;
      r_rd_s       <= w_rd_s_nxt;
      r_regf_we    <= w_regf_we_nxt;
      r_is_load    <= w_is_load_nxt;
      r_wb_valid   <= w_wb_valid_nxt;
      r_wb_rd_s    <= w_wb_rd_s_nxt;
      r_wb_regf_we <= w_wb_regf_we_nxt;
      r_wb_rd_v    <= w_wb_rd_v_nxt;
      r_misalign   <= w_misalign_nxt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_rmask = r_dmem_rmask;
  assign bus.dmem_wmask = r_dmem_wmask;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.stall      = w_stall;
  assign bus.wb_valid   = r_wb_valid;
  assign bus.wb_rd_s    = r_wb_rd_s;
  assign bus.wb_regf_we = r_wb_regf_we;
  assign bus.wb_rd_v    = r_wb_rd_v;
  assign bus.misalign   = r_misalign;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, misalignment and reset abort.
module tb_mem_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_stage_if #(.STALL_CNT_W(32)) bus ();

  mem_stage #(.STALL_CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Move to the middle of the next cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_req();
    bus.req_valid      = 1'b0;
    bus.req_addr       = 32'h0;
    bus.req_rmask      = 4'b0000;
    bus.req_wmask      = 4'b0000;
    bus.req_wdata      = 32'h0;
    bus.req_funct3     = 3'b000;
    bus.req_rd_s       = 5'd0;
    bus.req_regf_we    = 1'b0;
    bus.req_alu_result = 32'h0;
  endtask

  // One aligned load/store: accept, one-cycle mask pulse, `waits` empty WAIT cycles, response.
  task automatic mem_txn(input string tag, input logic [31:0] addr, input logic [3:0] rmask,
                         input logic [3:0] wmask, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [4:0] rd, input logic we,
                         input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_rd_v,
                         input logic exp_we);
    bus.req_valid   = 1'b1;
    bus.req_addr    = addr;
    bus.req_rmask   = rmask;
    bus.req_wmask   = wmask;
    bus.req_wdata   = wdata;
    bus.req_funct3  = f3;
    bus.req_rd_s    = rd;
    bus.req_regf_we = we;
    bus.dmem_resp   = 1'b0;
    #1;
    chk({tag, " idle stall"}, 32'(bus.stall), 32'd1);
    tick();
    chk({tag, " issue addr"}, bus.dmem_addr, exp_addr);
    chk({tag, " issue rmask"}, 32'(bus.dmem_rmask), 32'(rmask));
    chk({tag, " issue wmask"}, 32'(bus.dmem_wmask), 32'(wmask));
    chk({tag, " issue stall"}, 32'(bus.stall), 32'd1);
    if (wmask != 4'b0000) chk({tag, " issue wdata"}, bus.dmem_wdata, wdata);
    tick();
    for (int i = 0; i < waits; i++) begin
      chk({tag, " wait masks"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
      chk({tag, " wait stall"}, 32'(bus.stall), 32'd1);
      chk({tag, " wait wb_valid"}, 32'(bus.wb_valid), 32'd0);
      chk({tag, " wait addr held"}, bus.dmem_addr, exp_addr);
      tick();
    end
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = rdata;
    #1;
    chk({tag, " resp stall"}, 32'(bus.stall), 32'd0);
    chk({tag, " resp masks"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    tick();
    bus.dmem_resp = 1'b0;
    idle_req();
    chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, " wb_rd_s"}, 32'(bus.wb_rd_s), 32'(rd));
    chk({tag, " wb_rd_v"}, bus.wb_rd_v, exp_rd_v);
    chk({tag, " wb_regf_we"}, 32'(bus.wb_regf_we), 32'(exp_we));
  endtask

  initial begin
    idle_req();
    bus.dmem_rdata = 32'h0;
    bus.dmem_resp  = 1'b0;

    // Reset state
    #3;
    chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst wb_rd_v", bus.wb_rd_v, 32'h0);
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    chk("rst misalign", 32'(bus.misalign), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: ALU result passes through in one cycle
    bus.req_valid      = 1'b1;
    bus.req_alu_result = 32'h0000_1234;
    bus.req_rd_s       = 5'd5;
    bus.req_regf_we    = 1'b1;
    #1;
    chk("add stall", 32'(bus.stall), 32'd0);
    tick();
    chk("add wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("add wb_rd_s", 32'(bus.wb_rd_s), 32'd5);
    chk("add wb_rd_v", bus.wb_rd_v, 32'h0000_1234);
    chk("add wb_regf_we", 32'(bus.wb_regf_we), 32'd1);
    // Writes to x0 are suppressed
    bus.req_rd_s       = 5'd0;
    bus.req_alu_result = 32'h0000_0055;
    tick();
    chk("x0 wb_regf_we", 32'(bus.wb_regf_we), 32'd0);
    chk("x0 wb_rd_v", bus.wb_rd_v, 32'h0000_0055);
    idle_req();
    tick();
    chk("bubble wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("add stall_cnt", bus.stall_cnt, 32'd0);

    // 2: lb from byte lane 3, one empty WAIT cycle
    mem_txn("lb", 32'h0000_1003, 4'b1000, 4'b0000, 32'h0, 3'b000, 5'd6, 1'b1, 1,
            32'h80FF_FFFF, 32'h0000_1000, 32'hFFFF_FF80, 1'b1);
    chk("lb stall_cnt", bus.stall_cnt, 32'd3);

    // 3: lhu upper half, then lw back-to-back
    mem_txn("lhu", 32'h0000_2002, 4'b1100, 4'b0000, 32'h0, 3'b101, 5'd9, 1'b1, 0,
            32'hBEEF_0000, 32'h0000_2000, 32'h0000_BEEF, 1'b1);
    mem_txn("lw", 32'h0000_2000, 4'b1111, 4'b0000, 32'h0, 3'b010, 5'd10, 1'b1, 0,
            32'hBEEF_0000, 32'h0000_2000, 32'hBEEF_0000, 1'b1);
    chk("lw stall_cnt", bus.stall_cnt, 32'd7);

    // 4: sh to the upper half; store never writes the register file
    mem_txn("sh", 32'h0000_3002, 4'b0000, 4'b1100, 32'hABCD_0000, 3'b001, 5'd7, 1'b1, 1,
            32'h1234_5678, 32'h0000_3000, 32'h0000_0000, 1'b0);
    chk("sh stall_cnt", bus.stall_cnt, 32'd10);

    // 5: misaligned lw is suppressed
    bus.req_valid   = 1'b1;
    bus.req_addr    = 32'h0000_4001;
    bus.req_rmask   = 4'b1111;
    bus.req_funct3  = 3'b010;
    bus.req_rd_s    = 5'd8;
    bus.req_regf_we = 1'b1;
    #1;
    chk("mis stall", 32'(bus.stall), 32'd0);
    tick();
    chk("mis pulse", 32'(bus.misalign), 32'd1);
    chk("mis rmask", 32'(bus.dmem_rmask), 32'd0);
    chk("mis wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("mis wb_regf_we", 32'(bus.wb_regf_we), 32'd0);
    chk("mis wb_rd_v", bus.wb_rd_v, 32'h0);
    idle_req();
    tick();
    chk("mis pulse end", 32'(bus.misalign), 32'd0);
    chk("mis stall_cnt", bus.stall_cnt, 32'd10);

    // 6: reset while waiting for a response; late response must be ignored
    bus.req_valid   = 1'b1;
    bus.req_addr    = 32'h0000_5000;
    bus.req_rmask   = 4'b0001;
    bus.req_funct3  = 3'b000;
    bus.req_rd_s    = 5'd11;
    bus.req_regf_we = 1'b1;
    tick();
    chk("abort issue rmask", 32'(bus.dmem_rmask), 32'd1);
    tick();
    chk("abort wait stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    idle_req();
    #1;
    chk("abort rst stall", 32'(bus.stall), 32'd0);
    chk("abort rst stall_cnt", bus.stall_cnt, 32'd0);
    chk("abort rst masks", 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("abort late resp stall", 32'(bus.stall), 32'd0);
    tick();
    bus.dmem_resp = 1'b0;
    chk("abort wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("abort stall_cnt", bus.stall_cnt, 32'd0);
    chk("abort rmask", 32'(bus.dmem_rmask), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
